// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage, 4-register pipeline.
// Generates EX forwarding selects, load-use stalls, branch flushes and the interrupt-entry sequence.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] id_ra,
  input  logic [1:0] id_rb,
  input  logic       id_use_ra,
  input  logic       id_use_rb,
  input  logic [1:0] ex_ra,
  input  logic [1:0] ex_rb,
  input  logic [1:0] ex_rd,
  input  logic       ex_RW,
  input  logic       ex_MR,
  input  logic       ex_br_taken,
  input  logic [1:0] mem_rd,
  input  logic       mem_RW,
  input  logic       mem_MR,
  input  logic [1:0] wb_rd,
  input  logic       wb_RW,
  input  logic       intr,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       epc_ld,
  output logic       vec_sel,
  output logic       int_ack
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_VECTOR = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] drn_cnt_q, drn_cnt_d;
  logic       luse_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  // A load result is not available in M yet, so only non-load M results may forward.
  function automatic logic [1:0] fwd_sel(
    input logic [1:0] src,
    input logic [1:0] m_rd,
    input logic       m_rw,
    input logic       m_mr,
    input logic [1:0] w_rd,
    input logic       w_rw
  );
    logic [1:0] sel;
    if (m_rw && !m_mr && (m_rd == src)) begin
      sel = 2'b01;
    end else if (w_rw && (w_rd == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Operand forwarding selects and load-use detection.
  always_comb begin
    fwd_a_s = fwd_sel(ex_ra, mem_rd, mem_RW, mem_MR, wb_rd, wb_RW);
    fwd_b_s = fwd_sel(ex_rb, mem_rd, mem_RW, mem_MR, wb_rd, wb_RW);
    luse_s  = ex_MR && ex_RW &&
              ((id_use_ra && (id_ra == ex_rd)) || (id_use_rb && (id_rb == ex_rd)));
  end

  // State and drain-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      drn_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      drn_cnt_q <= drn_cnt_d;
    end
  end

  // Next-state logic: a taken branch always takes precedence over interrupt entry.
  always_comb begin
    state_d   = state_q;
    drn_cnt_d = drn_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (ex_br_taken) begin
          state_d = ST_RUN;
        end else if (intr) begin
          state_d   = ST_DRAIN;
          drn_cnt_d = 2'd1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drn_cnt_q == 2'd0) begin
          state_d = ST_VECTOR;
        end else begin
          drn_cnt_d = drn_cnt_q - 2'd1;
        end
      end
      ST_VECTOR: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d   = ST_RUN;
        drn_cnt_d = 2'd0;
      end
    endcase
  end

  // Output logic; while reset is held the pipe is frozen and flushed.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    epc_ld     = 1'b0;
    vec_sel    = 1'b0;
    int_ack    = 1'b0;
    if (!rst_n) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      fwd_a = fwd_a_s;
      fwd_b = fwd_b_s;
      case (state_q)
        ST_RUN: begin
          if (ex_br_taken) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (intr) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            epc_ld     = 1'b1;
          end else if (luse_s) begin
            idex_flush = 1'b1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
        ST_DRAIN: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        ST_VECTOR: begin
          vec_sel    = 1'b1;
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          int_ack    = 1'b1;
          idex_flush = 1'b1;
        end
        default: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes model predictions, a monitor pops and compares.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [1:0] id_ra;
    logic [1:0] id_rb;
    logic       id_use_ra;
    logic       id_use_rb;
    logic [1:0] ex_ra;
    logic [1:0] ex_rb;
    logic [1:0] ex_rd;
    logic       ex_RW;
    logic       ex_MR;
    logic       ex_br_taken;
    logic [1:0] mem_rd;
    logic       mem_RW;
    logic       mem_MR;
    logic [1:0] wb_rd;
    logic       wb_RW;
    logic       intr;
  } in_t;

  typedef struct {
    logic [10:0] exp;
    string       tag;
  } sb_t;

  logic clk;
  logic rst_n;
  in_t  cur;
  logic pc_en, ifid_en, ifid_flush, idex_flush, epc_ld, vec_sel, int_ack;
  logic [1:0] fwd_a, fwd_b;

  sb_t sb[$];
  int  plan[$];   // upcoming interrupt-sequence cycles: 1 = drain, 2 = vector
  int  total;
  int  bad;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_ra(cur.id_ra), .id_rb(cur.id_rb),
    .id_use_ra(cur.id_use_ra), .id_use_rb(cur.id_use_rb),
    .ex_ra(cur.ex_ra), .ex_rb(cur.ex_rb), .ex_rd(cur.ex_rd),
    .ex_RW(cur.ex_RW), .ex_MR(cur.ex_MR), .ex_br_taken(cur.ex_br_taken),
    .mem_rd(cur.mem_rd), .mem_RW(cur.mem_RW), .mem_MR(cur.mem_MR),
    .wb_rd(cur.wb_rd), .wb_RW(cur.wb_RW), .intr(cur.intr),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .epc_ld(epc_ld), .vec_sel(vec_sel), .int_ack(int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] fsel(input logic [1:0] src, input in_t v);
    if (v.mem_RW && !v.mem_MR && v.mem_rd == src) return 2'b01;
    if (v.wb_RW && v.wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  // Prediction packed as {pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b, epc_ld, vec_sel, int_ack}.
  function automatic logic [10:0] pred(input logic r, input in_t v);
    logic [3:0] ctl;
    logic [2:0] irq;
    logic       luse;
    if (!r) return 11'b0011_0000_000;
    luse = v.ex_MR && v.ex_RW &&
           ((v.id_use_ra && v.id_ra == v.ex_rd) || (v.id_use_rb && v.id_rb == v.ex_rd));
    irq = 3'b000;
    if (plan.size() > 0 && plan[0] == 1) ctl = 4'b0011;
    else if (plan.size() > 0) begin ctl = 4'b1101; irq = 3'b011; end
    else if (v.ex_br_taken) ctl = 4'b1111;
    else if (v.intr) begin ctl = 4'b0011; irq = 3'b100; end
    else if (luse) ctl = 4'b0001;
    else ctl = 4'b1100;
    return {ctl, fsel(v.ex_ra, v), fsel(v.ex_rb, v), irq};
  endfunction

  task automatic advance(input logic r, input in_t v);
    if (!r) plan.delete();
    else if (plan.size() > 0) void'(plan.pop_front());
    else if (!v.ex_br_taken && v.intr) begin
      plan.push_back(1); plan.push_back(1); plan.push_back(2);
    end
  endtask

  // One cycle of stimulus: inputs and reset change between clock edges.
  task automatic step(input logic r, input in_t v, input string tag);
    sb_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    cur   = v;
    e.exp = pred(r, v);
    e.tag = tag;
    sb.push_back(e);
    advance(r, v);
  endtask

  // Monitor: compares on the falling edge whenever a prediction is pending.
  always @(negedge clk) begin
    sb_t e;
    logic [10:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b, epc_ld, vec_sel, int_ack};
      total = total + 1;
      if (act !== e.exp) begin
        bad = bad + 1;
        $display("FAIL %s: got %b expected %b (pc,ifid,iff,idf,fa,fb,epc,vec,ack)", e.tag, act, e.exp);
      end
    end
  end

  initial begin
    in_t z, v;
    int  wait_cyc;
    total = 0;
    bad   = 0;
    z     = '0;
    rst_n = 1'b0;
    cur   = z;

    v = z; v.intr = 1'b1;
    step(1'b0, v, "reset_hold");
    step(1'b0, v, "reset_hold2");
    step(1'b1, z, "reset_release");

    v = z; v.ex_ra = 2'd2; v.mem_rd = 2'd2; v.mem_RW = 1'b1; v.wb_rd = 2'd2; v.wb_RW = 1'b1;
    step(1'b1, v, "fwd_m_wins");
    v.mem_MR = 1'b1;
    step(1'b1, v, "fwd_load_in_m");
    v.ex_rb = 2'd3;
    step(1'b1, v, "fwd_b_nomatch");

    v = z; v.ex_MR = 1'b1; v.ex_RW = 1'b1; v.ex_rd = 2'd1; v.id_rb = 2'd1; v.id_use_rb = 1'b1;
    step(1'b1, v, "luse_stall");
    v = z; v.mem_MR = 1'b1; v.mem_RW = 1'b1; v.mem_rd = 2'd1; v.id_rb = 2'd1; v.id_use_rb = 1'b1;
    step(1'b1, v, "luse_cleared");
    v = z; v.ex_MR = 1'b1; v.ex_RW = 1'b1; v.ex_rd = 2'd1; v.id_rb = 2'd1;
    step(1'b1, v, "luse_unused_rb");

    v = z; v.ex_MR = 1'b1; v.ex_RW = 1'b1; v.ex_rd = 2'd1; v.id_ra = 2'd1; v.id_use_ra = 1'b1;
    v.ex_br_taken = 1'b1;
    step(1'b1, v, "branch_over_luse");

    v = z; v.intr = 1'b1;
    step(1'b1, v, "intr_entry");
    step(1'b1, z, "intr_drain1");
    step(1'b1, z, "intr_drain2");
    step(1'b1, z, "intr_vector");
    step(1'b1, z, "intr_back_run");

    v = z; v.intr = 1'b1; v.ex_br_taken = 1'b1;
    step(1'b1, v, "collide_branch");
    v.ex_br_taken = 1'b0;
    step(1'b1, v, "collide_entry");
    step(1'b1, z, "collide_drain1");
    step(1'b1, z, "collide_drain2");
    step(1'b1, z, "collide_vector");

    v = z; v.intr = 1'b1;
    step(1'b1, v, "abort_entry");
    step(1'b1, z, "abort_drain");
    step(1'b0, z, "abort_reset");
    step(1'b1, z, "abort_run1");
    step(1'b1, z, "abort_run2");
    step(1'b1, z, "abort_run3");

    for (int i = 0; i < 600; i++) begin
      v = in_t'({$urandom(), $urandom()});
      v.intr        = ($urandom_range(0, 5) == 0);
      v.ex_br_taken = ($urandom_range(0, 4) == 0);
      step(($urandom_range(0, 60) != 0), v, "random");
    end
    step(1'b1, z, "final_idle");

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      bad = bad + 1;
      $display("FAIL drain_scoreboard: pending=%0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
